keypad_debounce_scanner: RTL and testbench

- Upstream stage of the dot-matrix key display: drives the rows of the 4x4 keypad and samples its columns.
- Builds one result per full 4-row scan frame and debounces it across consecutive frames.
- Emits a single-cycle `key_valid` strobe with a 4-bit `key_code`, plus `key_held` and `multi_err` levels.
- The display stage latches `key_code` on `key_valid`.

---
 rtl/keypad_debounce_scanner.sv | 205 ++++++++++++++++++++
 tb/tb_keypad_debounce_scanner.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_debounce_scanner.sv
// ============================================================================
// keypad_debounce_scanner : 4x4 keypad row scanner with frame-level debounce
// Revision: 1.0
// ============================================================================
`default_nettype none

module keypad_debounce_scanner #(
  parameter int SCAN_TICKS     = 500000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] keypadCol,
  output logic [3:0] keypadRow,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_err
);

  localparam int                  TICK_W     = (SCAN_TICKS > 2) ? $clog2(SCAN_TICKS) : 1;
  localparam int                  STABLE_W   = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [TICK_W-1:0]   TICK_LAST  = TICK_W'(SCAN_TICKS - 1);
  localparam logic [STABLE_W-1:0] STABLE_MAX = STABLE_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    RES_NONE  = 2'd0,
    RES_KEY   = 2'd1,
    RES_MULTI = 2'd2
  } res_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_e;

  logic [TICK_W-1:0]   tick_q,       tick_d;
  logic [3:0]          row_q,        row_d;
  logic [1:0]          row_idx_q,    row_idx_d;
  res_e                acc_kind_q,   acc_kind_d;
  logic [3:0]          acc_code_q,   acc_code_d;
  res_e                prev_kind_q,  prev_kind_d;
  logic [3:0]          prev_code_q,  prev_code_d;
  logic [STABLE_W-1:0] stable_q,     stable_d;
  state_e              state_q,      state_d;
  logic [3:0]          key_code_q,   key_code_d;
  logic                key_valid_q,  key_valid_d;
  logic                key_held_q,   key_held_d;
  logic                multi_err_q,  multi_err_d;

  logic                sample_now;
  logic                frame_end;
  logic                samp_single;
  logic                samp_multi;
  logic [1:0]          samp_col;
  logic [3:0]          samp_code;
  res_e                merged_kind;
  logic [3:0]          merged_code;
  logic [STABLE_W-1:0] stable_next;
  logic                debounced;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h7;  4'h1: k = 4'h4;  4'h2: k = 4'h1;  4'h3: k = 4'h0;
      4'h4: k = 4'h8;  4'h5: k = 4'h5;  4'h6: k = 4'h2;  4'h7: k = 4'hA;
      4'h8: k = 4'h9;  4'h9: k = 4'h6;  4'hA: k = 4'h3;  4'hB: k = 4'hB;
      4'hC: k = 4'hC;  4'hD: k = 4'hD;  4'hE: k = 4'hE;  default: k = 4'hF;
    endcase
    return k;
  endfunction

  // Columns are read directly: the SCAN_TICKS-1 cycles before each sample act as settling time.
  always_comb begin
    samp_single = 1'b0;
    samp_multi  = 1'b0;
    samp_col    = 2'd0;
    case (keypadCol)
      4'b1111: ;
      4'b1110: begin samp_single = 1'b1; samp_col = 2'd0; end
      4'b1101: begin samp_single = 1'b1; samp_col = 2'd1; end
      4'b1011: begin samp_single = 1'b1; samp_col = 2'd2; end
      4'b0111: begin samp_single = 1'b1; samp_col = 2'd3; end
      default: samp_multi = 1'b1;
    endcase
    samp_code = key_map(row_idx_q, samp_col);

    merged_kind = acc_kind_q;
    merged_code = acc_code_q;
    if (samp_multi) begin
      merged_kind = RES_MULTI;
      merged_code = 4'd0;
    end else if (samp_single) begin
      if (acc_kind_q == RES_NONE) begin
        merged_kind = RES_KEY;
        merged_code = samp_code;
      end else begin
        merged_kind = RES_MULTI;
        merged_code = 4'd0;
      end
    end

    sample_now = (tick_q == TICK_LAST);
    frame_end  = sample_now && (row_idx_q == 2'd3);

    // Non-key results carry code 0, so comparing kind and code together is exact.
    if ((merged_kind == prev_kind_q) && (merged_code == prev_code_q))
      stable_next = (stable_q == STABLE_MAX) ? stable_q : stable_q + STABLE_W'(1);
    else
      stable_next = STABLE_W'(1);
    debounced = (stable_next == STABLE_MAX);
  end

  always_comb begin
    tick_d      = sample_now ? '0 : tick_q + TICK_W'(1);
    row_d       = row_q;
    row_idx_d   = row_idx_q;
    acc_kind_d  = acc_kind_q;
    acc_code_d  = acc_code_q;
    prev_kind_d = prev_kind_q;
    prev_code_d = prev_code_q;
    stable_d    = stable_q;
    state_d     = state_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    multi_err_d = multi_err_q;

    if (sample_now) begin
      row_d      = {row_q[2:0], row_q[3]};
      row_idx_d  = row_idx_q + 2'd1;
      acc_kind_d = merged_kind;
      acc_code_d = merged_code;
    end

    if (frame_end) begin
      acc_kind_d  = RES_NONE;
      acc_code_d  = 4'd0;
      prev_kind_d = merged_kind;
      prev_code_d = merged_code;
      stable_d    = stable_next;
      if (debounced) begin
        multi_err_d = (merged_kind == RES_MULTI);
        case (state_q)
          ST_IDLE: begin
            if (merged_kind == RES_KEY) begin
              key_code_d  = merged_code;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              state_d     = ST_HELD;
            end
          end
          default: begin
            // Any other key or a multi press must be preceded by a debounced release.
            if (merged_kind == RES_NONE) begin
              key_held_d = 1'b0;
              state_d    = ST_IDLE;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q      <= '0;
      row_q       <= 4'b1110;
      row_idx_q   <= 2'd0;
      acc_kind_q  <= RES_NONE;
      acc_code_q  <= 4'd0;
      prev_kind_q <= RES_NONE;
      prev_code_q <= 4'd0;
      stable_q    <= '0;
      state_q     <= ST_IDLE;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      multi_err_q <= 1'b0;
    end else begin
      tick_q      <= tick_d;
      row_q       <= row_d;
      row_idx_q   <= row_idx_d;
      acc_kind_q  <= acc_kind_d;
      acc_code_q  <= acc_code_d;
      prev_kind_q <= prev_kind_d;
      prev_code_q <= prev_code_d;
      stable_q    <= stable_d;
      state_q     <= state_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      multi_err_q <= multi_err_d;
    end
  end

  assign keypadRow = row_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign multi_err = multi_err_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_debounce_scanner.sv
// ============================================================================
// tb_keypad_debounce_scanner : frame-table bench with a keypad model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_keypad_debounce_scanner;

  localparam int ST = 4;
  localparam int DS = 3;
  localparam int FRAME = 4 * ST;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] keypadCol;
  logic [3:0] keypadRow;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       multi_err;
  logic [15:0] keys = 16'h0;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] keys;
    logic        v;
    logic [3:0]  code;
    logic        held;
    logic        multi;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  keypad_debounce_scanner #(
    .SCAN_TICKS     (ST),
    .DEBOUNCE_SCANS (DS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .keypadCol (keypadCol),
    .keypadRow (keypadRow),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .multi_err (multi_err)
  );

  function automatic logic [3:0] key_at(input int r, input int c);
    logic [3:0] m [16];
    m = '{4'h7, 4'h4, 4'h1, 4'h0,
          4'h8, 4'h5, 4'h2, 4'hA,
          4'h9, 4'h6, 4'h3, 4'hB,
          4'hC, 4'hD, 4'hE, 4'hF};
    return m[r * 4 + c];
  endfunction

  // Passive keypad: a pressed key shorts its column low while its row is driven low.
  always_comb begin
    keypadCol = 4'b1111;
    for (int r = 0; r < 4; r++)
      if (keypadRow[r] == 1'b0)
        for (int c = 0; c < 4; c++)
          if (keys[key_at(r, c)]) keypadCol[c] = 1'b0;
  end

  function automatic logic [15:0] kb(input int n);
    logic [15:0] one;
    one = 16'h0001;
    return one << n;
  endfunction

  task automatic add(input logic [15:0] k, input logic v, input logic [3:0] code,
                     input logic held, input logic multi, input int n);
    vec_t e;
    e.keys = k; e.v = v; e.code = code; e.held = held; e.multi = multi;
    for (int i = 0; i < n; i++) tbl.push_back(e);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_row"},   {12'h0, keypadRow}, 16'h000E);
    check({tag, "_code"},  {12'h0, key_code},  16'h0);
    check({tag, "_valid"}, {15'h0, key_valid}, 16'h0);
    check({tag, "_held"},  {15'h0, key_held},  16'h0);
    check({tag, "_multi"}, {15'h0, multi_err}, 16'h0);
  endtask

  // Entered just before the first edge of a frame; leaves 1 time unit after its last edge.
  task automatic run_frame(input vec_t v);
    vec_t e;
    logic [3:0] exp_row;
    exp_q.push_back(v);
    keys = v.keys;
    for (int k = 1; k <= FRAME; k++) begin
      @(posedge clk);
      #1;
      exp_row = 4'b1111 ^ (4'b0001 << ((k / ST) % 4));
      check("row_drive", {12'h0, keypadRow}, {12'h0, exp_row});
      if (k < FRAME) begin
        check("valid_off_frame_end", {15'h0, key_valid}, 16'h0);
      end else begin
        e = exp_q.pop_front();
        check("key_valid", {15'h0, key_valid}, {15'h0, e.v});
        check("key_code",  {12'h0, key_code},  {12'h0, e.code});
        check("key_held",  {15'h0, key_held},  {15'h0, e.held});
        check("multi_err", {15'h0, multi_err}, {15'h0, e.multi});
      end
    end
  endtask

  initial begin
    #1_000_000;
    bad++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    // single press of 5 and release
    add(kb(5), 0, 4'h5 & 4'h0, 0, 0, 2);
    add(kb(5), 1, 4'h5, 1, 0, 1);
    add(kb(5), 0, 4'h5, 1, 0, 1);
    add(16'h0, 0, 4'h5, 1, 0, 2);
    add(16'h0, 0, 4'h5, 0, 0, 1);
    // bounce on F in alternate frames
    for (int i = 0; i < 10; i++) add((i % 2 == 0) ? kb(15) : 16'h0, 0, 4'h5, 0, 0, 1);
    add(16'h0, 0, 4'h5, 0, 0, 2);
    // keys 1 and 2 in different rows
    add(kb(1) | kb(2), 0, 4'h5, 0, 0, 2);
    add(kb(1) | kb(2), 0, 4'h5, 0, 1, 2);
    add(16'h0, 0, 4'h5, 0, 1, 2);
    add(16'h0, 0, 4'h5, 0, 0, 1);
    // keys 7 and 4 in the same row, then a debounced key clears multi_err and is accepted
    add(kb(7) | kb(4), 0, 4'h5, 0, 0, 2);
    add(kb(7) | kb(4), 0, 4'h5, 0, 1, 1);
    add(kb(9), 0, 4'h5, 0, 1, 2);
    add(kb(9), 1, 4'h9, 1, 0, 1);
    add(16'h0, 0, 4'h9, 1, 0, 2);
    add(16'h0, 0, 4'h9, 0, 0, 1);
    // key change while held
    add(kb(7), 0, 4'h9, 0, 0, 2);
    add(kb(7), 1, 4'h7, 1, 0, 1);
    add(kb(10), 0, 4'h7, 1, 0, 3);
    add(16'h0, 0, 4'h7, 1, 0, 2);
    add(16'h0, 0, 4'h7, 0, 0, 1);
    add(kb(10), 0, 4'h7, 0, 0, 2);
    add(kb(10), 1, 4'hA, 1, 0, 1);
    add(kb(10), 0, 4'hA, 1, 0, 1);
    // multi while held, then the same key again: no second strobe
    add(kb(10) | kb(11), 0, 4'hA, 1, 0, 2);
    add(kb(10) | kb(11), 0, 4'hA, 1, 1, 1);
    add(kb(10), 0, 4'hA, 1, 1, 2);
    add(kb(10), 0, 4'hA, 1, 0, 1);
    add(16'h0, 0, 4'hA, 1, 0, 2);
    add(16'h0, 0, 4'hA, 0, 0, 1);
    // key 0 (row 0, column 3)
    add(kb(0), 0, 4'hA, 0, 0, 2);
    add(kb(0), 1, 4'h0, 1, 0, 1);
    add(16'h0, 0, 4'h0, 1, 0, 2);
    add(16'h0, 0, 4'h0, 0, 0, 1);
    // key C accepted, then reset while held
    add(kb(12), 0, 4'h0, 0, 0, 2);
    add(kb(12), 1, 4'hC, 1, 0, 1);

    rst = 1'b1;
    #1 rst = 1'b0;
    #1 check_reset_values("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i]) run_frame(tbl[i]);

    // reset mid-frame while HELD, key C still pressed
    repeat (6) @(posedge clk);
    #2 rst = 1'b0;
    #1 check_reset_values("midreset");
    @(negedge clk);
    check_reset_values("midreset_hold");
    rst = 1'b1;

    tbl.delete();
    add(kb(12), 0, 4'h0, 0, 0, 2);
    add(kb(12), 1, 4'hC, 1, 0, 1);
    add(16'h0, 0, 4'hC, 1, 0, 2);
    add(16'h0, 0, 4'hC, 0, 0, 1);
    foreach (tbl[i]) run_frame(tbl[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
